// File: rtl/mc_control.sv
// Multi-cycle MIPS control sequencer: one FSM steps the shared ALU and memory port.
// Optional sticky illegal-instruction trap: define MC_CONTROL_TRAP_EN.
module mc_control #(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_beq,
    output logic       pc_write_bne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       trap
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        MULWAIT = 4'd7,
        RWB     = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        ADDIEX  = 4'd11,
        ADDIWB  = 4'd12,
        TRAP    = 4'd13
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b1000;

    state_t     st, nst;
    logic [3:0] cnt, cnt_n;
    logic       is_sw, is_sw_n;
    logic       is_bne, is_bne_n;

    // zero only qualifies the branch strobes inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= FETCH;
            cnt    <= 4'd0;
            is_sw  <= 1'b0;
            is_bne <= 1'b0;
        end else begin
            st     <= nst;
            cnt    <= cnt_n;
            is_sw  <= is_sw_n;
            is_bne <= is_bne_n;
        end
    end

    always_comb begin
        nst          = st;
        cnt_n        = cnt;
        is_sw_n      = is_sw;
        is_bne_n     = is_bne;
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_source    = 2'b00;
        alu_op       = 4'b0000;
        instr_done   = 1'b0;
        trap         = 1'b0;
        unique case (st)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) nst = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = OP_ADD;
                // remember lw/sw and beq/bne so later states ignore the IR
                is_sw_n   = (opcode == 6'd43);
                is_bne_n  = (opcode == 6'd5);
                unique case (opcode)
                    6'd0:         nst = EXEC;
                    6'd35, 6'd43: nst = MEMADR;
                    6'd8:         nst = ADDIEX;
                    6'd4, 6'd5:   nst = BRANCH;
                    6'd2:         nst = JUMP;
                    default:      nst = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = OP_ADD;
                nst       = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) nst = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) nst = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                nst       = RWB;
                unique case (funct)
                    6'd32: alu_op = OP_ADD;
                    6'd34: alu_op = OP_SUB;
                    6'd36: alu_op = 4'b0000;
                    6'd37: alu_op = 4'b0001;
                    6'd38: alu_op = 4'b1101;
                    6'd39: alu_op = 4'b1100;
                    6'd24: begin
                        alu_op = OP_MULT;
                        if (MULT_CYCLES > 1) begin
                            cnt_n = 4'(MULT_CYCLES - 2);
                            nst   = MULWAIT;
                        end
                    end
                    default: nst = TRAP;
                endcase
            end
            MULWAIT: begin
                alu_src_a = 1'b1;
                alu_op    = OP_MULT;
                if (cnt == 4'd0) nst = RWB;
                else cnt_n = cnt - 4'd1;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = OP_ADD;
                nst       = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = OP_SUB;
                pc_source    = 2'b01;
                pc_write_beq = !is_bne;
                pc_write_bne = is_bne;
                instr_done   = 1'b1;
                nst          = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                nst        = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
`ifdef MC_CONTROL_TRAP_EN
                nst  = TRAP;
`else
                instr_done = 1'b1;
                nst        = FETCH;
`endif
            end
            default: nst = FETCH;
        endcase
        // strobes are dead while reset is held
        if (!rst_n) begin
            pc_write     = 1'b0;
            pc_write_beq = 1'b0;
            pc_write_bne = 1'b0;
            i_or_d       = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            ir_write     = 1'b0;
            reg_dst      = 1'b0;
            reg_write    = 1'b0;
            mem_to_reg   = 1'b0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'b00;
            pc_source    = 2'b00;
            alu_op       = 4'b0000;
            instr_done   = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues hand-computed per-cycle vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_beq, pc_write_bne, i_or_d;
    logic       mem_read, mem_write, ir_write, reg_dst, reg_write;
    logic       mem_to_reg, alu_src_a, instr_done, trap;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    mc_control #(.MULT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_beq(pc_write_beq),
        .pc_write_bne(pc_write_bne), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .state(state), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] PW    = 13'h1000;
    localparam logic [12:0] PWBEQ = 13'h0800;
    localparam logic [12:0] PWBNE = 13'h0400;
    localparam logic [12:0] IORD  = 13'h0200;
    localparam logic [12:0] MRD   = 13'h0100;
    localparam logic [12:0] MWR   = 13'h0080;
    localparam logic [12:0] IRW   = 13'h0040;
    localparam logic [12:0] RDST  = 13'h0020;
    localparam logic [12:0] RWR   = 13'h0010;
    localparam logic [12:0] M2R   = 13'h0008;
    localparam logic [12:0] SRCA  = 13'h0004;
    localparam logic [12:0] DONE  = 13'h0002;
    localparam logic [12:0] TRP   = 13'h0001;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic [24:0] act;
    assign act = {pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, reg_write, mem_to_reg,
                  alu_src_a, instr_done, trap, alu_src_b, pc_source,
                  alu_op, state};

    always @(negedge clk) begin
        if (q.size() != 0) begin
            ent_t e;
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", e.tag, act, e.v);
            end
        end
    end

    task automatic cyc(input string tag, input bit r, input logic [5:0] op,
                       input logic [5:0] fn, input bit z, input bit mr,
                       input logic [3:0] st, input logic [12:0] s,
                       input logic [1:0] b, input logic [1:0] p,
                       input logic [3:0] a);
        ent_t e;
        rst_n     = r;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        e.tag = tag;
        e.v   = {s, b, p, a, st};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        cyc(tag, 1, op, fn, 0, 1, 4'd0, MRD | IRW | PW, 2'b01, 2'b00, 4'b0010);
    endtask

    task automatic decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        cyc(tag, 1, op, fn, 0, 1, 4'd1, 13'h0, 2'b11, 2'b00, 4'b0010);
    endtask

    task automatic trap_seq(input string tag, input logic [5:0] op, input logic [5:0] fn);
`ifdef MC_CONTROL_TRAP_EN
        cyc(tag, 1, op, fn, 0, 1, 4'd13, TRP, 2'b00, 2'b00, 4'b0000);
        cyc({tag, "_hold1"}, 1, op, fn, 0, 1, 4'd13, TRP, 2'b00, 2'b00, 4'b0000);
        cyc({tag, "_hold2"}, 1, 0, 0, 0, 1, 4'd13, TRP, 2'b00, 2'b00, 4'b0000);
        cyc({tag, "_rst"}, 0, 0, 0, 0, 1, 4'd0, 13'h0, 2'b00, 2'b00, 4'b0000);
`else
        cyc(tag, 1, op, fn, 0, 1, 4'd13, TRP | DONE, 2'b00, 2'b00, 4'b0000);
`endif
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset0", 0, 0, 0, 0, 1, 4'd0, 13'h0, 2'b00, 2'b00, 4'b0000);
        cyc("reset1", 0, 0, 0, 0, 1, 4'd0, 13'h0, 2'b00, 2'b00, 4'b0000);

        fetch("add_fetch", 0, 32);
        decode("add_decode", 0, 32);
        cyc("add_exec", 1, 0, 32, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b0010);
        cyc("add_rwb", 1, 0, 32, 0, 1, 4'd8, RWR | RDST | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("lw_fetch", 35, 0);
        decode("lw_decode", 35, 0);
        cyc("lw_memadr", 1, 35, 0, 0, 1, 4'd2, SRCA, 2'b10, 2'b00, 4'b0010);
        for (int i = 0; i < 3; i++)
            cyc("lw_memrd_stall", 1, 35, 0, 0, 0, 4'd3, MRD | IORD, 2'b00, 2'b00, 4'b0000);
        cyc("lw_memrd_ready", 1, 35, 0, 0, 1, 4'd3, MRD | IORD, 2'b00, 2'b00, 4'b0000);
        cyc("lw_memwb", 1, 35, 0, 0, 1, 4'd4, RWR | M2R | DONE, 2'b00, 2'b00, 4'b0000);

        cyc("sw_fetch_stall", 1, 43, 0, 0, 0, 4'd0, MRD, 2'b01, 2'b00, 4'b0010);
        fetch("sw_fetch", 43, 0);
        decode("sw_decode", 43, 0);
        cyc("sw_memadr", 1, 43, 0, 0, 1, 4'd2, SRCA, 2'b10, 2'b00, 4'b0010);
        cyc("sw_memwr_stall", 1, 43, 0, 0, 0, 4'd5, MWR | IORD, 2'b00, 2'b00, 4'b0000);
        cyc("sw_memwr", 1, 43, 0, 0, 1, 4'd5, MWR | IORD | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("addi_fetch", 8, 0);
        decode("addi_decode", 8, 0);
        cyc("addi_ex", 1, 8, 0, 0, 1, 4'd11, SRCA, 2'b10, 2'b00, 4'b0010);
        cyc("addi_wb", 1, 8, 0, 0, 1, 4'd12, RWR | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("sub_fetch", 0, 34);
        decode("sub_decode", 0, 34);
        cyc("sub_exec", 1, 0, 34, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b0110);
        cyc("sub_rwb", 1, 0, 34, 0, 1, 4'd8, RWR | RDST | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("nor_fetch", 0, 39);
        decode("nor_decode", 0, 39);
        cyc("nor_exec", 1, 0, 39, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b1100);
        cyc("nor_rwb", 1, 0, 39, 0, 1, 4'd8, RWR | RDST | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("xor_fetch", 0, 38);
        decode("xor_decode", 0, 38);
        cyc("xor_exec", 1, 0, 38, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b1101);
        cyc("xor_rwb", 1, 0, 38, 0, 1, 4'd8, RWR | RDST | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("mult_fetch", 0, 24);
        decode("mult_decode", 0, 24);
        cyc("mult_exec", 1, 0, 24, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b1000);
        for (int i = 0; i < 3; i++)
            cyc("mult_wait", 1, 0, 24, 0, 1, 4'd7, SRCA, 2'b00, 2'b00, 4'b1000);
        cyc("mult_rwb", 1, 0, 24, 0, 1, 4'd8, RWR | RDST | DONE, 2'b00, 2'b00, 4'b0000);

        fetch("beq_fetch", 4, 0);
        decode("beq_decode", 4, 0);
        cyc("beq_branch", 1, 4, 0, 1, 1, 4'd9, SRCA | PWBEQ | DONE, 2'b00, 2'b01, 4'b0110);

        fetch("bne_fetch", 5, 0);
        decode("bne_decode", 5, 0);
        cyc("bne_branch", 1, 5, 0, 1, 1, 4'd9, SRCA | PWBNE | DONE, 2'b00, 2'b01, 4'b0110);

        fetch("j_fetch", 2, 0);
        decode("j_decode", 2, 0);
        cyc("j_jump", 1, 2, 0, 0, 1, 4'd10, PW | DONE, 2'b00, 2'b10, 4'b0000);

        fetch("badfn_fetch", 0, 63);
        decode("badfn_decode", 0, 63);
        cyc("badfn_exec", 1, 0, 63, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b0000);
        trap_seq("badfn_trap", 0, 63);

        fetch("op63_fetch", 63, 0);
        decode("op63_decode", 63, 0);
        trap_seq("op63_trap", 63, 0);

        fetch("mrst_fetch", 0, 24);
        decode("mrst_decode", 0, 24);
        cyc("mrst_exec", 1, 0, 24, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b1000);
        cyc("mrst_wait", 1, 0, 24, 0, 1, 4'd7, SRCA, 2'b00, 2'b00, 4'b1000);
        cyc("mrst_reset", 0, 0, 24, 0, 1, 4'd0, 13'h0, 2'b00, 2'b00, 4'b0000);
        cyc("mrst_reset_hold", 0, 0, 24, 0, 1, 4'd0, 13'h0, 2'b00, 2'b00, 4'b0000);
        fetch("mrst_refetch", 0, 32);
        decode("mrst_redecode", 0, 32);
        cyc("mrst_exec2", 1, 0, 32, 0, 1, 4'd6, SRCA, 2'b00, 2'b00, 4'b0010);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
